rf_access_ctrl: RTL and testbench

Request/response front end sitting directly upstream of a generated register file (e.g. counter_RF).
- Accepts single read/write transactions from a host over a valid/ready handshake.
- Drives the RF access port (address, read_en, write_en, write_data) and waits for access_complete or invalid_address.
- Returns read data and a status code over a valid/ready response channel, with a timeout guard against a stalled RF.

---
 rtl/rf_access_pkg.sv | 15 +
 rtl/rf_access_timer.sv | 27 ++
 rtl/rf_access_ctrl.sv | 108 ++++++++++
 tb/tb_rf_access_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_pkg.sv
// Shared types and status codes for the register-file access controller.
package rf_access_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_t;

   localparam logic [1:0] RF_ST_OK      = 2'b00;
   localparam logic [1:0] RF_ST_INVALID = 2'b01;
   localparam logic [1:0] RF_ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/rf_access_timer.sv
// Clear/enable wait counter; 'expired' marks the last permitted WAIT cycle.
module rf_access_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic res_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] count;

   // NOTE: sequential state uses non-blocking assignments and a synchronous reset only.
   always_ff @(posedge clk) begin
      if (!res_n || clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/rf_access_ctrl.sv
// Host-side request/response front end driving a generated register file port.
module rf_access_ctrl
   import rf_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_status,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  read_en,
   output logic                  write_en,
   output logic [DATA_WIDTH-1:0] write_data,
   input  logic [DATA_WIDTH-1:0] read_data,
   input  logic                  invalid_address,
   input  logic                  access_complete
);

   state_t state;
   logic   is_write;
   logic   expired;

   // Timer only runs while waiting, so it is already zero on entry to WAIT.
   rf_access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .res_n   (res_n),
      .clr     (state != WAIT),
      .en      (state == WAIT),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state      <= IDLE;
         is_write   <= 1'b0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_status <= RF_ST_OK;
         address    <= '0;
         read_en    <= 1'b0;
         write_en   <= 1'b0;
         write_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  is_write   <= req_write;
                  address    <= req_addr;
                  write_data <= req_wdata;
                  read_en    <= !req_write;
                  write_en   <= req_write;
                  req_ready  <= 1'b0;
                  state      <= ISSUE;
               end
            end

            // A zero-latency RF may complete during the strobe cycle itself.
            ISSUE, WAIT: begin
               read_en  <= 1'b0;
               write_en <= 1'b0;
               if (invalid_address) begin
                  rsp_status <= RF_ST_INVALID;
                  rsp_rdata  <= '0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (access_complete) begin
                  rsp_status <= RF_ST_OK;
                  rsp_rdata  <= is_write ? '0 : read_data;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (state == WAIT && expired) begin
                  rsp_status <= RF_ST_TIMEOUT;
                  rsp_rdata  <= '0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  state <= WAIT;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  rsp_rdata  <= '0;
                  rsp_status <= RF_ST_OK;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Randomised self-checking bench for rf_access_ctrl with a transaction-level reference model.
module tb_rf_access_ctrl;

   localparam int AW = 8;
   localparam int DW = 64;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          res_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_status;
   logic [AW-1:0] address;
   logic          read_en;
   logic          write_en;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;
   logic          invalid_address;
   logic          access_complete;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .res_n           (res_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_rdata       (rsp_rdata),
      .rsp_status      (rsp_status),
      .address         (address),
      .read_en         (read_en),
      .write_en        (write_en),
      .write_data      (write_data),
      .read_data       (read_data),
      .invalid_address (invalid_address),
      .access_complete (access_complete)
   );

   function automatic logic [DW-1:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      res_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({req_ready, rsp_valid, read_en, write_en, rsp_status} !== 6'b0 ||
             rsp_rdata !== '0 || address !== '0 || write_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: ready=%b valid=%b re=%b we=%b st=%b rdata=%h addr=%h wdata=%h, all must be 0",
                     i, req_ready, rsp_valid, read_en, write_en, rsp_status, rsp_rdata, address, write_data);
         end
      end
      res_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || read_en !== 1'b0 || write_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b valid=%b re=%b we=%b, required ready=1 others 0",
                  req_ready, rsp_valid, read_en, write_en);
      end
   endtask

   // One host transaction. lat = cycles after the strobe cycle at which the RF answers
   // (0 = same cycle as the strobe); lat > TO means the RF never answers in time.
   task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int lat, input bit inv, input logic [DW-1:0] rfd,
                         input int hold, input bit late);
      logic [1:0]    exp_st;
      logic [DW-1:0] exp_rd;
      int            exp_c;
      int            c;
      int            w;
      bit            got;
      bit            both;
      bit            hit;

      // Reference model: outcome and response cycle from the protocol rules.
      if (lat <= TO) begin
         exp_c = 2 + lat;
         if (inv) begin
            exp_st = 2'b01;
            exp_rd = '0;
         end else begin
            exp_st = 2'b00;
            exp_rd = wr ? '0 : rfd;
         end
      end else begin
         exp_c  = 2 + TO;
         exp_st = 2'b10;
         exp_rd = '0;
      end
      both = inv ? 1'($urandom_range(0, 1)) : 1'b1;

      w = 0;
      while (req_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL req_ready_wait: req_ready=%b, required 1", req_ready);
      end

      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_wdata = rand64();

      c   = 1;
      got = 1'b0;
      while (!got && c <= TO + 10) begin
         access_complete = 1'b0;
         invalid_address = 1'b0;
         read_data       = rand64();
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
            n_checks++;
            if (c != exp_c || rsp_status !== exp_st || rsp_rdata !== exp_rd ||
                read_en !== 1'b0 || write_en !== 1'b0) begin
               n_fail++;
               $display("FAIL response: cycle=%0d st=%b rdata=%h re=%b we=%b, required cycle=%0d st=%b rdata=%h strobes 0",
                        c, rsp_status, rsp_rdata, read_en, write_en, exp_c, exp_st, exp_rd);
            end
         end else begin
            n_checks++;
            if (read_en !== (c == 1 && !wr) || write_en !== (c == 1 && wr) ||
                req_ready !== 1'b0 || address !== a || write_data !== wd) begin
               n_fail++;
               $display("FAIL access_port cycle %0d: re=%b we=%b ready=%b addr=%h wdata=%h, required re=%b we=%b ready=0 addr=%h wdata=%h",
                        c, read_en, write_en, req_ready, address, write_data,
                        (c == 1 && !wr), (c == 1 && wr), a, wd);
            end
            hit = (c == 1 + lat);
            if (hit) begin
               access_complete = both;
               invalid_address = inv;
               read_data       = rfd;
            end
            @(negedge clk);
            c++;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL rsp_valid_wait: no response within %0d cycles, required at cycle %0d", TO + 10, exp_c);
      end

      rsp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         access_complete = late && (h == 1);
         invalid_address = late && (h == 1) && 1'($urandom_range(0, 1));
         read_data       = rand64();
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_status !== exp_st || rsp_rdata !== exp_rd ||
             req_ready !== 1'b0 || read_en !== 1'b0 || write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_hold %0d: valid=%b st=%b rdata=%h ready=%b re=%b we=%b, required valid=1 st=%b rdata=%h ready=0 strobes 0",
                     h, rsp_valid, rsp_status, rsp_rdata, req_ready, read_en, write_en, exp_st, exp_rd);
         end
      end
      access_complete = 1'b0;
      invalid_address = 1'b0;
      rsp_ready       = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_status !== 2'b00 || rsp_rdata !== '0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rsp_release: valid=%b st=%b rdata=%h ready=%b, required valid=0 st=00 rdata=0 ready=1",
                  rsp_valid, rsp_status, rsp_rdata, req_ready);
      end

      if (late) begin
         access_complete = 1'b1;
         invalid_address = 1'($urandom_range(0, 1));
         @(negedge clk);
         access_complete = 1'b0;
         invalid_address = 1'b0;
         n_checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || read_en !== 1'b0 || write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL late_complete_idle: valid=%b ready=%b re=%b we=%b, required valid=0 ready=1 strobes 0",
                     rsp_valid, req_ready, read_en, write_en);
         end
      end
   endtask

   task automatic test_write();
      do_txn(1'b1, 8'h00, 64'h0000_1234_5678_9ABC, 1, 1'b0, rand64(), 0, 1'b0);
   endtask

   task automatic test_read_hold();
      do_txn(1'b0, 8'h00, rand64(), 1, 1'b0, 64'h0000_0000_0000_002A, 5, 1'b0);
   endtask

   task automatic test_invalid();
      do_txn(1'b0, 8'h7F, rand64(), 1, 1'b1, rand64(), 1, 1'b0);
      do_txn(1'b1, 8'h80, rand64(), 3, 1'b1, rand64(), 0, 1'b0);
   endtask

   task automatic test_timeout();
      do_txn(1'b0, 8'h05, rand64(), 1000, 1'b0, rand64(), 3, 1'b1);
      do_txn(1'b0, 8'h06, rand64(), 2, 1'b0, 64'hCAFE_F00D_0000_0001, 0, 1'b0);
   endtask

   task automatic test_boundaries();
      do_txn(1'b0, 8'h11, rand64(), TO, 1'b0, 64'h0000_0000_DEAD_BEEF, 0, 1'b0);
      do_txn(1'b1, 8'h12, rand64(), TO + 1, 1'b0, rand64(), 0, 1'b0);
      do_txn(1'b0, 8'h13, rand64(), 0, 1'b0, 64'h1111_2222_3333_4444, 0, 1'b0);
      do_txn(1'b1, 8'h14, rand64(), 0, 1'b1, rand64(), 0, 1'b0);
   endtask

   task automatic test_reset_midop();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'h10;
      req_wdata = rand64();
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      res_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || read_en !== 1'b0 || write_en !== 1'b0 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_wait: valid=%b re=%b we=%b ready=%b, required all 0",
                  rsp_valid, read_en, write_en, req_ready);
      end
      res_n = 1'b1;
      for (int i = 0; i < TO + 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b0 || read_en !== 1'b0 || write_en !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_wait %0d: valid=%b re=%b we=%b ready=%b, required valid=0 strobes 0 ready=1",
                     i, rsp_valid, read_en, write_en, req_ready);
         end
      end

      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h20;
      req_wdata = rand64();
      @(negedge clk);
      req_valid       = 1'b0;
      access_complete = 1'b1;
      @(negedge clk);
      access_complete = 1'b0;
      rsp_ready       = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_latency_resp: valid=%b, required 1", rsp_valid);
      end
      res_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_status !== 2'b00 || rsp_rdata !== '0 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_resp: valid=%b st=%b rdata=%h ready=%b, required all 0",
                  rsp_valid, rsp_status, rsp_rdata, req_ready);
      end
      res_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || write_en !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_resp: valid=%b ready=%b we=%b, required valid=0 ready=1 we=0",
                  rsp_valid, req_ready, write_en);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         do_txn(1'($urandom_range(0, 1)), AW'($urandom), rand64(),
                int'($urandom_range(0, TO + 4)), ($urandom_range(0, 3) == 0), rand64(),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 6; t++) begin
         do_txn(1'(t % 2), AW'(t * 17), rand64(), 1, 1'b0, rand64(), 0, 1'b0);
      end
   endtask

   initial begin
      res_n           = 1'b0;
      req_valid       = 1'b0;
      req_write       = 1'b0;
      req_addr        = '0;
      req_wdata       = '0;
      rsp_ready       = 1'b0;
      read_data       = '0;
      invalid_address = 1'b0;
      access_complete = 1'b0;

      test_reset();
      test_write();
      test_read_hold();
      test_invalid();
      test_timeout();
      test_boundaries();
      test_reset_midop();
      test_back_to_back();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
